// File: rtl/seg7_scan_capture_pkg.sv
// Shared definitions for the seven-segment scan capture block.
// SEG_HEX_EN: when defined, hex letter patterns decode to A..F and the
// blank/bad codes move to a 5-bit form (digits widens to 20 bits).
package seg7_scan_capture_pkg;

`ifdef SEG_HEX_EN
  localparam int unsigned CODE_W = 5;
  localparam logic [CODE_W-1:0] CODE_BLANK = 5'h10;
  localparam logic [CODE_W-1:0] CODE_BAD   = 5'h11;
`else
  localparam int unsigned CODE_W = 4;
  localparam logic [CODE_W-1:0] CODE_BLANK = 4'hF;
  localparam logic [CODE_W-1:0] CODE_BAD   = 4'hE;
`endif

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGITS_W   = NUM_DIGITS * CODE_W;

  // Active-low segment patterns ordered {a,b,c,d,e,f,g}
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
`ifdef SEG_HEX_EN
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
`endif
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low one-hot digit selects
  localparam logic [3:0] POS_D0   = 4'b1110;
  localparam logic [3:0] POS_D1   = 4'b1101;
  localparam logic [3:0] POS_D2   = 4'b1011;
  localparam logic [3:0] POS_D3   = 4'b0111;
  localparam logic [3:0] POS_IDLE = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HOLD
  } state_t;

  // One sampled cycle of the scan bus
  typedef struct packed {
    logic [3:0] pos;
    logic [6:0] seg;
    logic       dp;
  } scan_t;

  localparam scan_t SCAN_IDLE = '{pos: POS_IDLE, seg: SEG_BLANK, dp: 1'b1};

  function automatic logic pos_valid(input logic [3:0] p);
    return (p == POS_D0) || (p == POS_D1) || (p == POS_D2) || (p == POS_D3);
  endfunction

  function automatic logic [1:0] pos_index(input logic [3:0] p);
    logic [1:0] idx;
    case (p)
      POS_D1:  idx = 2'd1;
      POS_D2:  idx = 2'd2;
      POS_D3:  idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational seven-segment pattern to digit code decoder.
// SEG_HEX_EN adds the hex letter patterns A..F.
module seg7_pattern_decode
  import seg7_scan_capture_pkg::*;
(
  input  logic [6:0]        pattern,
  output logic [CODE_W-1:0] code_c
);

  // Map an active-low {a..g} pattern to its code; unknown shapes are bad
  always_comb begin
    code_c = CODE_BAD;
    case (pattern)
      SEG_0:     code_c = CODE_W'(4'h0);
      SEG_1:     code_c = CODE_W'(4'h1);
      SEG_2:     code_c = CODE_W'(4'h2);
      SEG_3:     code_c = CODE_W'(4'h3);
      SEG_4:     code_c = CODE_W'(4'h4);
      SEG_5:     code_c = CODE_W'(4'h5);
      SEG_6:     code_c = CODE_W'(4'h6);
      SEG_7:     code_c = CODE_W'(4'h7);
      SEG_8:     code_c = CODE_W'(4'h8);
      SEG_9:     code_c = CODE_W'(4'h9);
`ifdef SEG_HEX_EN
      SEG_A:     code_c = CODE_W'(4'hA);
      SEG_B:     code_c = CODE_W'(4'hB);
      SEG_C:     code_c = CODE_W'(4'hC);
      SEG_D:     code_c = CODE_W'(4'hD);
      SEG_E:     code_c = CODE_W'(4'hE);
      SEG_F:     code_c = CODE_W'(4'hF);
`endif
      SEG_BLANK: code_c = CODE_BLANK;
      default:   code_c = CODE_BAD;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Receiver for the multiplexed 4-digit seven-segment scan bus: samples the
// bus, rejects ghosting with a stability window, decodes each position and
// assembles complete frames. SEG_HEX_EN enables hex letter decoding.
module seg7_scan_capture
  import seg7_scan_capture_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                a,
  input  logic                b,
  input  logic                c,
  input  logic                d,
  input  logic                e,
  input  logic                f,
  input  logic                g,
  input  logic                dp,
  input  logic [3:0]          pos,
  output logic [DIGITS_W-1:0] digits,
  output logic [3:0]          dps,
  output logic                frame_valid,
  output logic                stale,
  output logic                bad_digit
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  scan_t smp;
  scan_t smp_prev;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             capture_c;
  logic             changed_c;
  logic             valid_c;

  logic [CODE_W-1:0] dec_code_c;
  logic [1:0]        idx_c;

  logic [NUM_DIGITS-1:0][CODE_W-1:0] shadow;
  logic [NUM_DIGITS-1:0][CODE_W-1:0] shadow_next_c;
  logic [NUM_DIGITS-1:0]             shadow_dp;
  logic [NUM_DIGITS-1:0]             shadow_dp_next_c;
  logic [NUM_DIGITS-1:0]             seen;
  logic [NUM_DIGITS-1:0]             seen_next_c;
  logic                              bad_next_c;
  logic [TO_W-1:0]                   tcnt;

  // Input sample stage plus one-cycle history for the stability compare
  always_ff @(posedge clk) begin
    if (reset) begin
      smp      <= SCAN_IDLE;
      smp_prev <= SCAN_IDLE;
    end else begin
      smp      <= {pos, a, b, c, d, e, f, g, dp};
      smp_prev <= smp;
    end
  end

  assign changed_c = (smp != smp_prev);
  assign valid_c   = pos_valid(smp.pos);
  assign idx_c     = pos_index(smp.pos);

  // Stability FSM state and run-length register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Stability FSM next-state: capture once per stable run of STABLE_CYCLES samples
  always_comb begin
    state_next = state;
    count_next = count;
    capture_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (valid_c) begin
          state_next = ST_SETTLE;
          count_next = CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (changed_c) begin
          state_next = valid_c ? ST_SETTLE : ST_IDLE;
          count_next = valid_c ? CNT_W'(1) : '0;
        end else if (count == CNT_W'(STABLE_CYCLES - 1)) begin
          capture_c  = 1'b1;
          state_next = ST_HOLD;
          count_next = CNT_W'(STABLE_CYCLES);
        end else begin
          count_next = count + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (changed_c) begin
          state_next = valid_c ? ST_SETTLE : ST_IDLE;
          count_next = valid_c ? CNT_W'(1) : '0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        count_next = '0;
      end
    endcase
  end

  seg7_pattern_decode u_decode (
    .pattern (smp.seg),
    .code_c  (dec_code_c)
  );

  // Next shadow contents including the position captured this cycle
  always_comb begin
    shadow_next_c    = shadow;
    shadow_dp_next_c = shadow_dp;
    seen_next_c      = seen;
    if (capture_c) begin
      shadow_next_c[idx_c]    = dec_code_c;
      shadow_dp_next_c[idx_c] = ~smp.dp;
      seen_next_c[idx_c]      = 1'b1;
    end
  end

  // Flag any bad code in the frame about to be published
  always_comb begin
    bad_next_c = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (shadow_next_c[i] == CODE_BAD) bad_next_c = 1'b1;
    end
  end

  // Shadow capture, frame publication and stale supervision
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow      <= {NUM_DIGITS{CODE_BLANK}};
      shadow_dp   <= '0;
      seen        <= '0;
      tcnt        <= '0;
      digits      <= {NUM_DIGITS{CODE_BLANK}};
      dps         <= '0;
      frame_valid <= 1'b0;
      stale       <= 1'b0;
      bad_digit   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (capture_c) begin
        shadow    <= shadow_next_c;
        shadow_dp <= shadow_dp_next_c;
        tcnt      <= '0;
        if (&seen_next_c) begin
          digits      <= shadow_next_c;
          dps         <= shadow_dp_next_c;
          frame_valid <= 1'b1;
          bad_digit   <= bad_next_c;
          stale       <= 1'b0;
          seen        <= '0;
        end else begin
          seen <= seen_next_c;
        end
      end else if (tcnt != TO_W'(TIMEOUT_CYCLES)) begin
        tcnt <= tcnt + TO_W'(1);
        if (tcnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          stale <= 1'b1;
          seen  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Self-checking bench for seg7_scan_capture: directed scenarios plus random
// scan dwells, compared every cycle against a pin-level run-length model.
module tb_seg7_scan_capture;

  localparam int STABLE  = 4;
  localparam int TIMEOUT = 64;
`ifdef SEG_HEX_EN
  localparam int CW   = 5;
  localparam int NPAT = 16;
  localparam logic [CW-1:0] BLANK = 5'h10;
  localparam logic [CW-1:0] BAD   = 5'h11;
`else
  localparam int CW   = 4;
  localparam int NPAT = 10;
  localparam logic [CW-1:0] BLANK = 4'hF;
  localparam logic [CW-1:0] BAD   = 4'hE;
`endif
  localparam int DW = 4 * CW;

  localparam logic [3:0] P0 = 4'b1110;
  localparam logic [3:0] P1 = 4'b1101;
  localparam logic [3:0] P2 = 4'b1011;
  localparam logic [3:0] P3 = 4'b0111;
  localparam logic [3:0] PI = 4'b1111;

  logic clk = 1'b0;
  logic reset;
  logic a, b, c, d, e, f, g, dp;
  logic [3:0] pos;
  logic [DW-1:0] digits;
  logic [3:0] dps;
  logic frame_valid, stale, bad_digit;

  seg7_scan_capture #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp),
    .pos(pos),
    .digits(digits), .dps(dps), .frame_valid(frame_valid),
    .stale(stale), .bad_digit(bad_digit)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int fv_seen  = 0;

  logic [6:0] pat_tab [16];

  // Reference model state
  logic [CW-1:0] m_shadow [4];
  logic [3:0]    m_sdp, m_seen, m_dps;
  logic [DW-1:0] m_digits;
  logic          m_fv, m_stale, m_bad;
  int            m_tcnt;
  int            run;
  logic [11:0]   last_pins;
  logic          pend_cap;
  int            pend_idx;
  logic [CW-1:0] pend_code;
  logic          pend_dp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pack(input logic [CW-1:0] c3, input logic [CW-1:0] c2,
                                         input logic [CW-1:0] c1, input logic [CW-1:0] c0);
    return {c3, c2, c1, c0};
  endfunction

  function automatic logic [CW-1:0] model_decode(input logic [6:0] p);
    for (int i = 0; i < NPAT; i++) if (pat_tab[i] == p) return CW'(i);
    if (p == 7'b1111111) return BLANK;
    return BAD;
  endfunction

  function automatic int pos_to_idx(input logic [3:0] p);
    logic [3:0] m;
    for (int i = 0; i < 4; i++) begin
      m = ~(4'b0001 << i);
      if (p == m) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_shadow[i] = BLANK;
    m_sdp = '0; m_seen = '0; m_dps = '0;
    m_digits = pack(BLANK, BLANK, BLANK, BLANK);
    m_fv = 1'b0; m_stale = 1'b0; m_bad = 1'b0; m_tcnt = 0;
    run = 0; pend_cap = 1'b0;
  endtask

  // One clock edge of frame/timeout behaviour given whether a capture lands
  task automatic model_edge(input logic cap, input int ci, input logic [CW-1:0] cc, input logic cd);
    m_fv = 1'b0;
    if (cap) begin
      m_shadow[ci] = cc; m_sdp[ci] = cd; m_seen[ci] = 1'b1; m_tcnt = 0;
      if (m_seen == 4'hF) begin
        m_digits = pack(m_shadow[3], m_shadow[2], m_shadow[1], m_shadow[0]);
        m_dps = m_sdp; m_fv = 1'b1; m_seen = '0; m_stale = 1'b0;
        m_bad = 1'b0;
        for (int i = 0; i < 4; i++) if (m_shadow[i] == BAD) m_bad = 1'b1;
      end
    end else if (m_tcnt < TIMEOUT) begin
      m_tcnt++;
      if (m_tcnt == TIMEOUT) begin
        m_stale = 1'b1; m_seen = '0;
      end
    end
  endtask

  task automatic check_outputs();
    check("digits", 32'(digits), 32'(m_digits));
    check("dps", 32'(dps), 32'(m_dps));
    check("frame_valid", 32'(frame_valid), 32'(m_fv));
    check("stale", 32'(stale), 32'(m_stale));
    check("bad_digit", 32'(bad_digit), 32'(m_bad));
    if (frame_valid === 1'b1) fv_seen++;
  endtask

  // Check previous edge, drive pins for the next edge, advance the model
  task automatic step(input logic [3:0] pp, input logic [6:0] ss, input logic dd, input logic rr);
    logic [11:0]   pins;
    logic          cap;
    int            ci, idx;
    logic [CW-1:0] cc;
    logic          cd;
    @(negedge clk);
    check_outputs();
    pins = {pp, ss, dd};
    reset = rr; pos = pp; {a, b, c, d, e, f, g} = ss; dp = dd;
    cap = pend_cap; ci = pend_idx; cc = pend_code; cd = pend_dp;
    pend_cap = 1'b0;
    if (rr) begin
      model_reset();
    end else begin
      if (run != 0 && pins == last_pins) run++;
      else run = 1;
      last_pins = pins;
      idx = pos_to_idx(pp);
      if (idx >= 0 && run == STABLE) begin
        pend_cap = 1'b1; pend_idx = idx; pend_code = model_decode(ss); pend_dp = ~dd;
      end
      model_edge(cap, ci, cc, cd);
    end
  endtask

  task automatic dwell(input logic [3:0] pp, input logic [6:0] ss, input logic dd, input int len);
    for (int i = 0; i < len; i++) step(pp, ss, dd, 1'b0);
  endtask

  task automatic idle(input int len);
    dwell(PI, 7'b1111111, 1'b1, len);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int fv0;
    logic [3:0] rp;
    logic [6:0] rs;
    logic [CW-1:0] hx;

    pat_tab[0]  = 7'b0000001; pat_tab[1]  = 7'b1001111; pat_tab[2]  = 7'b0010010;
    pat_tab[3]  = 7'b0000110; pat_tab[4]  = 7'b1001100; pat_tab[5]  = 7'b0100100;
    pat_tab[6]  = 7'b0100000; pat_tab[7]  = 7'b0001111; pat_tab[8]  = 7'b0000000;
    pat_tab[9]  = 7'b0000100; pat_tab[10] = 7'b0001000; pat_tab[11] = 7'b1100000;
    pat_tab[12] = 7'b0110001; pat_tab[13] = 7'b1000010; pat_tab[14] = 7'b0110000;
    pat_tab[15] = 7'b0111000;

    reset = 1'b1; pos = PI; {a, b, c, d, e, f, g} = 7'h7F; dp = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) step(PI, 7'h7F, 1'b1, 1'b1);
    idle(3);

    // Frame capture 3,1,0,5
    fv0 = fv_seen;
    dwell(P0, pat_tab[3], 1'b1, 8);
    dwell(P1, pat_tab[1], 1'b1, 8);
    dwell(P2, pat_tab[0], 1'b1, 8);
    dwell(P3, pat_tab[5], 1'b1, 8);
    idle(2);
    check("t1_frames", 32'(fv_seen - fv0), 32'd1);
    check("t1_digits", 32'(digits), 32'(pack(CW'(5), CW'(0), CW'(1), CW'(3))));
    check("t1_dps", 32'(dps), 32'd0);
    check("t1_bad", 32'(bad_digit), 32'd0);

    // Glitch rejection: short dwell on digit0 must not count as seen
    fv0 = fv_seen;
    dwell(P0, pat_tab[7], 1'b1, 3);
    dwell(P1, pat_tab[2], 1'b1, 6);
    dwell(P2, pat_tab[2], 1'b1, 6);
    dwell(P3, pat_tab[2], 1'b1, 6);
    idle(2);
    check("t2_no_frame", 32'(fv_seen - fv0), 32'd0);
    dwell(P0, pat_tab[9], 1'b1, 6);
    idle(2);
    check("t2_frame", 32'(fv_seen - fv0), 32'd1);
    check("t2_digits", 32'(digits), 32'(pack(CW'(2), CW'(2), CW'(2), CW'(9))));

    // Blank and invalid patterns, dp on digit0
    dwell(P0, pat_tab[8], 1'b0, 6);
    dwell(P1, 7'b1111111, 1'b1, 6);
    dwell(P2, 7'b1010101, 1'b1, 6);
    dwell(P3, pat_tab[2], 1'b1, 6);
    idle(2);
    check("t3_digits", 32'(digits), 32'(pack(CW'(2), BAD, BLANK, CW'(8))));
    check("t3_dps", 32'(dps), 32'b0001);
    check("t3_bad", 32'(bad_digit), 32'd1);

    // Timeout with digits retained, then recovery
    idle(70);
    check("t4_stale", 32'(stale), 32'd1);
    check("t4_retained", 32'(digits), 32'(pack(CW'(2), BAD, BLANK, CW'(8))));
    dwell(P0, pat_tab[4], 1'b1, 6);
    dwell(P1, pat_tab[4], 1'b1, 6);
    dwell(P2, pat_tab[4], 1'b1, 6);
    dwell(P3, pat_tab[4], 1'b1, 6);
    idle(2);
    check("t4_recover", 32'(stale), 32'd0);

    // Reset mid-scan discards the partial frame
    dwell(P0, pat_tab[6], 1'b1, 6);
    dwell(P1, pat_tab[6], 1'b1, 5);
    step(P2, pat_tab[6], 1'b1, 1'b1);
    step(P2, pat_tab[6], 1'b1, 1'b0);
    check("t5_digits", 32'(digits), 32'(pack(BLANK, BLANK, BLANK, BLANK)));
    check("t5_bad", 32'(bad_digit), 32'd0);
    fv0 = fv_seen;
    dwell(P2, pat_tab[1], 1'b1, 6);
    dwell(P3, pat_tab[1], 1'b1, 6);
    idle(2);
    check("t5_partial", 32'(fv_seen - fv0), 32'd0);
    dwell(P0, pat_tab[1], 1'b1, 6);
    dwell(P1, pat_tab[1], 1'b1, 6);
    idle(2);
    check("t5_frame", 32'(fv_seen - fv0), 32'd1);

    // Hex letter A on all positions
    hx = (NPAT == 16) ? CW'(4'hA) : BAD;
    dwell(P0, 7'b0001000, 1'b1, 6);
    dwell(P1, 7'b0001000, 1'b1, 6);
    dwell(P2, 7'b0001000, 1'b1, 6);
    dwell(P3, 7'b0001000, 1'b1, 6);
    idle(2);
    check("t6_digits", 32'(digits), 32'(pack(hx, hx, hx, hx)));
    check("t6_bad", 32'(bad_digit), (NPAT == 16) ? 32'd0 : 32'd1);

    // Random scan dwells with occasional idles and resets
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 49) == 0) begin
        for (int i = 0; i < int'($urandom_range(1, 2)); i++) step(PI, 7'h7F, 1'b1, 1'b1);
      end else if ($urandom_range(0, 39) == 0) begin
        idle(70);
      end else begin
        if ($urandom_range(0, 9) < 8) rp = ~(4'b0001 << $urandom_range(0, 3));
        else rp = 4'($urandom_range(0, 15));
        case ($urandom_range(0, 9))
          0:       rs = 7'b1111111;
          1, 2:    rs = 7'($urandom_range(0, 127));
          default: rs = pat_tab[$urandom_range(0, NPAT - 1)];
        endcase
        dwell(rp, rs, 1'($urandom_range(0, 1)), int'($urandom_range(1, 9)));
      end
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
